mlp_layer_seq: RTL and testbench

Controller that time-multiplexes one MAC unit across all neurons of an MLP layer. It buffers one input vector of S1_NUM samples, then for each neuron clears the MAC, streams S1_NUM input/weight pairs from a synchronous weight memory, captures the MAC result and hands it downstream over a valid/ready port. It sits between the input sample stream, the weight ROM and the shared MAC, and replaces one-MAC-per-neuron instantiation.

---
 rtl/mlp_pkg.sv | 31 +++
 rtl/mlp_layer_seq_if.sv | 44 ++++
 rtl/mlp_in_buf.sv | 37 +++
 rtl/mlp_layer_seq.sv | 179 +++++++++++++++++
 tb/tb_mlp_layer_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared state encoding and width helpers for the time-multiplexed MLP layer,
// its input buffer and the MAC that it drives.
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLR,
        ST_FEED,
        ST_WAIT,
        ST_OUT
    } state_t;

    // S1_NUM worst-case products summed without overflow.
    function automatic int mac_out_width(input int data_width, input int s1_num);
        return 2 * data_width + s1_num - 1;
    endfunction

    function automatic int waddr_width(input int neurons, input int s1_num);
        return (neurons * s1_num > 1) ? $clog2(neurons * s1_num) : 1;
    endfunction

    function automatic int idx_width(input int neurons);
        return (neurons > 1) ? $clog2(neurons) : 1;
    endfunction

    function automatic int sel_width(input int s1_num);
        return (s1_num > 1) ? $clog2(s1_num) : 1;
    endfunction

endpackage

// File: rtl/mlp_layer_seq_if.sv
// Sample stream, weight memory, shared MAC and result port of mlp_layer_seq.
// master = the sequencer, slave = the surrounding environment.
interface mlp_layer_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int S1_NUM     = 8,
    parameter int NEURONS    = 2
);
    import mlp_pkg::*;

    localparam int MAC_OUT_WIDTH = mac_out_width(DATA_WIDTH, S1_NUM);
    localparam int WADDR_W       = waddr_width(NEURONS, S1_NUM);
    localparam int IDX_W         = idx_width(NEURONS);

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;
    logic [WADDR_W-1:0]       w_addr;
    logic [DATA_WIDTH-1:0]    w_rdata;
    logic                     mac_clr;
    logic                     mac_en;
    logic [DATA_WIDTH-1:0]    mac_inp;
    logic [DATA_WIDTH-1:0]    mac_weight;
    logic [MAC_OUT_WIDTH-1:0] mac_out;
    logic                     mac_rdy;
    logic                     res_valid;
    logic                     res_ready;
    logic [MAC_OUT_WIDTH-1:0] res_data;
    logic [IDX_W-1:0]         res_idx;
    logic                     done;
    logic                     busy;

    modport master (
        input  in_valid, in_data, w_rdata, mac_out, mac_rdy, res_ready,
        output in_ready, w_addr, mac_clr, mac_en, mac_inp, mac_weight,
               res_valid, res_data, res_idx, done, busy
    );

    modport slave (
        output in_valid, in_data, w_rdata, mac_out, mac_rdy, res_ready,
        input  in_ready, w_addr, mac_clr, mac_en, mac_inp, mac_weight,
               res_valid, res_data, res_idx, done, busy
    );

endinterface

// File: rtl/mlp_in_buf.sv
// Input-vector register file: one write port filled while loading,
// combinational read selected by the feed index.
module mlp_in_buf
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int S1_NUM     = 8,
    parameter int SEL_W      = sel_width(S1_NUM)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] rd_vec [S1_NUM];

    // Contents are don't-care after reset, so entries carry no reset.
    generate
        for (genvar gi = 0; gi < S1_NUM; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_sel == SEL_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign rd_vec[gi] = entry_reg;
        end
    endgenerate

    assign rd_data = rd_vec[rd_sel];

endmodule

// File: rtl/mlp_layer_seq.sv
// Sequences one shared MAC across all neurons of an MLP layer.
// Optional MLP_RELU_EN: clamp each captured neuron result to max(mac_out, 0).
module mlp_layer_seq
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int S1_NUM     = 8,
    parameter int NEURONS    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mlp_layer_seq_if.master bus
);

    localparam int MAC_OUT_WIDTH = mac_out_width(DATA_WIDTH, S1_NUM);
    localparam int WADDR_W       = waddr_width(NEURONS, S1_NUM);
    localparam int IDX_W         = idx_width(NEURONS);
    localparam int SEL_W         = sel_width(S1_NUM);
    localparam int LAST_J        = S1_NUM - 1;
    localparam int LAST_N        = NEURONS - 1;

    state_t                   state_reg, state_next;
    logic [SEL_W-1:0]         j_reg, j_next;
    logic [IDX_W-1:0]         n_reg, n_next;
    logic [MAC_OUT_WIDTH-1:0] res_reg, res_next;
    logic                     done_reg, done_next;
    logic                     alive_reg;

    logic                     in_fire;
    logic                     j_last;
    logic                     n_last;
    logic [DATA_WIDTH-1:0]    buf_rd;
    logic [MAC_OUT_WIDTH-1:0] mac_capt;
    logic [WADDR_W-1:0]       base_addr;
    logic [WADDR_W-1:0]       next_off;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign j_last    = (j_reg == SEL_W'(LAST_J));
    assign n_last    = (n_reg == IDX_W'(LAST_N));
    assign base_addr = WADDR_W'(int'(n_reg) * S1_NUM);
    assign next_off  = WADDR_W'(int'(j_reg) + 1);

    mlp_in_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .S1_NUM     (S1_NUM),
        .SEL_W      (SEL_W)
    ) u_in_buf (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_sel  (j_reg),
        .wr_data (bus.in_data),
        .rd_sel  (j_reg),
        .rd_data (buf_rd)
    );

`ifdef MLP_RELU_EN
    assign mac_capt = bus.mac_out[MAC_OUT_WIDTH-1] ? '0 : bus.mac_out;
`else
    assign mac_capt = bus.mac_out;
`endif

    // alive_reg keeps in_ready low while reset is held and releases it on the
    // first clock after, without a combinational path from reset to outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            j_reg     <= '0;
            n_reg     <= '0;
            res_reg   <= '0;
            done_reg  <= 1'b0;
            alive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            j_reg     <= j_next;
            n_reg     <= n_next;
            res_reg   <= res_next;
            done_reg  <= done_next;
            alive_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        j_next     = j_reg;
        n_next     = n_reg;
        res_next   = res_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_fire) begin
                    j_next     = SEL_W'(1);
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    if (j_last) begin
                        j_next     = '0;
                        n_next     = '0;
                        state_next = ST_CLR;
                    end else begin
                        j_next = j_reg + 1'b1;
                    end
                end
            end
            ST_CLR: begin
                state_next = ST_FEED;
            end
            ST_FEED: begin
                if (j_last) begin
                    j_next     = '0;
                    state_next = ST_WAIT;
                end else begin
                    j_next = j_reg + 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mac_rdy) begin
                    res_next   = mac_capt;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    if (n_last) begin
                        n_next     = '0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        n_next     = n_reg + 1'b1;
                        state_next = ST_CLR;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Weight address runs one ahead of the operand because the memory is synchronous.
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.mac_clr    = 1'b0;
        bus.mac_en     = 1'b0;
        bus.mac_inp    = '0;
        bus.mac_weight = '0;
        bus.w_addr     = '0;
        bus.res_valid  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_LOAD: begin
                bus.in_ready = alive_reg;
            end
            ST_CLR: begin
                bus.mac_clr = 1'b1;
                bus.w_addr  = base_addr;
            end
            ST_FEED: begin
                bus.mac_en     = 1'b1;
                bus.mac_inp    = buf_rd;
                bus.mac_weight = bus.w_rdata;
                if (!j_last) begin
                    bus.w_addr = base_addr + next_off;
                end
            end
            ST_OUT: begin
                bus.res_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.done     = done_reg;
    assign bus.res_data = res_reg;
    assign bus.res_idx  = n_reg;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Directed bench for mlp_layer_seq with a behavioural MAC (registered ready)
// and a synchronous weight ROM; expected results are hand-computed constants.
module tb_mlp_layer_seq;

    localparam int DW = 8;
    localparam int S1 = 8;
    localparam int NN = 2;
    localparam int MW = 2 * DW + S1 - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mlp_layer_seq_if #(.DATA_WIDTH(DW), .S1_NUM(S1), .NEURONS(NN)) bus ();

    mlp_layer_seq #(
        .DATA_WIDTH (DW),
        .S1_NUM     (S1),
        .NEURONS    (NN)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Weight ROM and MAC models
    logic signed [DW-1:0] wmem [NN*S1];
    logic signed [MW-1:0] acc;
    logic                 en_q;
    logic                 rdy_q;

    always @(posedge clk) bus.w_rdata <= wmem[bus.w_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            en_q  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            en_q  <= bus.mac_en;
            rdy_q <= en_q && !bus.mac_en;
            if (bus.mac_clr)
                acc <= '0;
            else if (bus.mac_en)
                acc <= acc + $signed(bus.mac_inp) * $signed(bus.mac_weight);
        end
    end

    assign bus.mac_out = acc;
    assign bus.mac_rdy = rdy_q;

    // Monitors
    int     cyc = 0;
    int     done_cnt = 0;
    int     bad_cnt = 0;
    int     clr_cyc = 0;
    logic   rv_prev = 1'b0;
    int     lat_q[$];
    int     idx_q[$];
    longint data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.in_ready && (bus.mac_clr || bus.mac_en || bus.res_valid)) bad_cnt++;
        if (bus.mac_clr) clr_cyc = cyc;
        if (bus.res_valid && !rv_prev) lat_q.push_back(cyc - clr_cyc);
        rv_prev = bus.res_valid;
        if (bus.res_valid && bus.res_ready) begin
            idx_q.push_back(int'(bus.res_idx));
            data_q.push_back(longint'($signed(bus.res_data)));
            $display("result idx=%0d data=%0d at cycle %0d", bus.res_idx, $signed(bus.res_data), cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

`ifdef MLP_RELU_EN
    function automatic longint relu(input longint v);
        return (v < 0) ? 0 : v;
    endfunction
`else
    function automatic longint relu(input longint v);
        return v;
    endfunction
`endif

    task automatic set_w(input int w0, input int w1);
        for (int j = 0; j < S1; j++) begin
            wmem[j]      = DW'(w0);
            wmem[S1 + j] = DW'(w1);
        end
    endtask

    task automatic send(input int d);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load_vec(input int s[S1], input int gap, input int from);
        for (int j = from; j < S1; j++) begin
            send(s[j]);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int waited = 0;
        while (done_cnt < target && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        if (done_cnt < target) check({tag, "_timeout"}, done_cnt, target);
        repeat (3) @(posedge clk);
        #1;
        check(tag, done_cnt, target);
    endtask

    task automatic check_res(input string tag, input longint e0, input longint e1);
        check({tag, "_count"}, idx_q.size(), 2);
        if (idx_q.size() == 2) begin
            check({tag, "_idx0"}, idx_q[0], 0);
            check({tag, "_data0"}, data_q[0], e0);
            check({tag, "_idx1"}, idx_q[1], 1);
            check({tag, "_data1"}, data_q[1], e1);
        end
        check({tag, "_lat_count"}, lat_q.size(), 2);
        foreach (lat_q[i]) check({tag, "_clr_to_valid"}, lat_q[i], S1 + 3);
        idx_q.delete();
        data_q.delete();
        lat_q.delete();
    endtask

    task automatic wait_out(input int idx, input string tag);
        int waited = 0;
        @(negedge clk);
        while (!(bus.res_valid && int'(bus.res_idx) == idx) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check(tag, bus.res_valid, 1);
    endtask

    initial begin
        int s[S1];
        int waited;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.res_ready = 1'b1;
        set_w(0, 0);

        // Reset state
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_mac_en", bus.mac_en, 0);
        check("rst_mac_clr", bus.mac_clr, 0);
        check("rst_w_addr", bus.w_addr, 0);
        check("rst_res_data", bus.res_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_busy", bus.busy, 0);

        // V1: samples 1, weights 2 / -3, contiguous load
        foreach (s[i]) s[i] = 1;
        set_w(2, -3);
        @(posedge clk); #1;
        load_vec(s, 0, 0);
        wait_done(1, "v1_done");
        check_res("v1", 16, relu(-24));

        // V2: same data, in_valid every other cycle
        load_vec(s, 1, 0);
        wait_done(2, "v2_done");
        check_res("v2", 16, relu(-24));
        check("v2_in_ready_while_busy", bad_cnt, 0);

        // V3: most negative operands, no overflow
        foreach (s[i]) s[i] = -128;
        set_w(-128, -128);
        load_vec(s, 0, 0);
        wait_done(3, "v3_done");
        check_res("v3", 131072, 131072);

        // V4: downstream stall on neuron 0
        foreach (s[i]) s[i] = 1;
        set_w(2, -3);
        bus.res_ready = 1'b0;
        load_vec(s, 0, 0);
        wait_out(0, "v4_res_valid");
        for (int k = 0; k < 5; k++) begin
            check("v4_hold_data", $signed(bus.res_data), 16);
            check("v4_hold_idx", bus.res_idx, 0);
            check("v4_no_clr", bus.mac_clr, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("v4_clr_before_hs", bus.mac_clr, 0);
        @(negedge clk);
        check("v4_n1_clr", bus.mac_clr, 1);
        check("v4_n1_idx", bus.res_idx, 1);
        wait_done(4, "v4_done");
        check_res("v4", 16, relu(-24));

        // V5: reset in the middle of neuron 1 FEED
        @(posedge clk); #1;
        load_vec(s, 0, 0);
        waited = 0;
        @(negedge clk);
        while (!(bus.mac_en && int'(bus.res_idx) == 1) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("v5_reach_n1_feed", bus.mac_en, 1);
        rst = 1'b1;
        #1;
        check("v5_rst_mac_en", bus.mac_en, 0);
        check("v5_rst_mac_inp", bus.mac_inp, 0);
        check("v5_rst_busy", bus.busy, 0);
        check("v5_rst_in_ready", bus.in_ready, 0);
        check("v5_rst_w_addr", bus.w_addr, 0);
        check("v5_rst_res_idx", bus.res_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        idx_q.delete();
        data_q.delete();
        lat_q.delete();
        check("v5_no_done", done_cnt, 4);

        // V6/V7: fresh vector 1..8, then second vector handshaking on done
        foreach (s[i]) s[i] = i + 1;
        set_w(1, -3);
        load_vec(s, 0, 0);
        wait_out(1, "b2b_last_out");
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(1);
        @(negedge clk);
        check("b2b_done_pulse", bus.done, 1);
        check("b2b_in_ready", bus.in_ready, 1);
        check("b2b_idle", bus.busy, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_accepted", bus.busy, 1);
        check_res("v6", 36, relu(-108));
        foreach (s[i]) s[i] = 1;
        load_vec(s, 0, 1);
        wait_done(6, "v7_done");
        check_res("v7", 8, relu(-24));
        check("in_ready_while_busy", bad_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
